// File: rtl/pe_link_pkg.sv
// -----------------------------------------------------------------------------
// pe_link_pkg
// Shared definitions for the overlay PE link switch.
//   - Link vector layout: [W-1] valid, [W-2] ready (for the opposite direction),
//     [W-3:0] data. VLD_BIT/RDY_BIT describe the default 130-bit link; the
//     vld_bit()/rdy_bit() helpers give the same positions for any width.
//   - src_sel_t encodes which side feeds a destination FIFO.
// No ports (package).
// -----------------------------------------------------------------------------
package pe_link_pkg;

    localparam int LINK_WIDTH_DEF = 130;
    localparam int VLD_BIT        = LINK_WIDTH_DEF - 1;
    localparam int RDY_BIT        = LINK_WIDTH_DEF - 2;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_EAST  = 2'd1,
        SRC_WEST  = 2'd2,
        SRC_SOUTH = 2'd3
    } src_sel_t;

    function automatic int vld_bit(input int w);
        return w - 1;
    endfunction

    function automatic int rdy_bit(input int w);
        return w - 2;
    endfunction

    function automatic bit is_pow2_ge2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pe_link_fifo.sv
// -----------------------------------------------------------------------------
// pe_link_fifo
// Register-array FIFO buffering one routed link stream.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high; empties the FIFO (pointers/count)
//   push   in   write din this cycle (ignored when full)
//   din    in   DATA_WIDTH write data
//   pop    in   remove head this cycle (ignored when empty)
//   dout   out  head word, all zeros while empty
//   full   out  count == DEPTH
//   empty  out  count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module pe_link_fifo
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    import pe_link_pkg::*;

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    // Local guards keep the FIFO safe even if a caller ignores full/empty.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pe_route3.sv
// -----------------------------------------------------------------------------
// pe_route3
// Statically routed 3-port (east/west/south) link switch used as an overlay PE
// tile. Each destination D whose SRC_D is non-zero owns a FIFO written from the
// selected source side and drained toward D. Traffic is gated until ap_start.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   ap_start       in   run enable, latched on the first high cycle
//   in_from_east   in   {valid, ready for out_to_east stream, data}
//   in_from_west   in   same layout, west side
//   in_from_south  in   same layout, south side
//   out_to_east    out  {valid, ready for stream from east, data}
//   out_to_west    out  same layout, west side
//   out_to_south   out  same layout, south side
// SRC_* encoding: 0 none, 1 east, 2 west, 3 south. Loopback is allowed; a
// source may feed at most one destination.
// -----------------------------------------------------------------------------
module pe_route3
#(
    parameter int LINK_WIDTH = 130,
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_EAST   = 0,
    parameter int SRC_WEST   = 0,
    parameter int SRC_SOUTH  = 0
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [LINK_WIDTH-1:0] in_from_east,
    input  logic [LINK_WIDTH-1:0] in_from_west,
    input  logic [LINK_WIDTH-1:0] in_from_south,
    output logic [LINK_WIDTH-1:0] out_to_east,
    output logic [LINK_WIDTH-1:0] out_to_west,
    output logic [LINK_WIDTH-1:0] out_to_south
);
    import pe_link_pkg::*;

    localparam int VLD    = vld_bit(LINK_WIDTH);
    localparam int RDY    = rdy_bit(LINK_WIDTH);
    localparam int DATA_W = LINK_WIDTH - 2;
    localparam int NPORT  = 3;    // port index: 0 east, 1 west, 2 south

    // Source side feeding destination d (src_sel_t encoding).
    function automatic int src_of(input int d);
        case (d)
            0:       return SRC_EAST;
            1:       return SRC_WEST;
            default: return SRC_SOUTH;
        endcase
    endfunction

    // Destination fed by source port s, or -1 when s feeds nothing.
    function automatic int dst_of(input int s);
        for (int d = 0; d < NPORT; d++) begin
            if (src_of(d) == s + 1) begin
                return d;
            end
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if (!is_pow2_ge2(FIFO_DEPTH)) begin : g_bad_depth
        $error("pe_route3: FIFO_DEPTH must be a power of two >= 2");
    end
    if (SRC_EAST < 0 || SRC_EAST > 3 || SRC_WEST < 0 || SRC_WEST > 3 ||
        SRC_SOUTH < 0 || SRC_SOUTH > 3) begin : g_bad_src
        $error("pe_route3: SRC_* must be in 0..3");
    end
    if ((SRC_EAST != int'(pe_link_pkg::SRC_NONE) &&
         (SRC_EAST == SRC_WEST || SRC_EAST == SRC_SOUTH)) ||
        (SRC_WEST != int'(pe_link_pkg::SRC_NONE) &&
         SRC_WEST == SRC_SOUTH)) begin : g_dup_src
        $error("pe_route3: a source may feed at most one destination");
    end
    if (LINK_WIDTH < 3) begin : g_bad_width
        $error("pe_route3: LINK_WIDTH must leave at least one data bit");
    end

    // ------------------------------------------------------------------
    // Link unpacking
    // ------------------------------------------------------------------
    logic                           run;
    logic [NPORT-1:0]               src_valid;
    logic [NPORT-1:0]               dst_ready;
    logic [NPORT-1:0][DATA_W-1:0]   src_data;
    logic [NPORT-1:0]               src_ready;
    logic [NPORT-1:0]               fifo_full;
    logic [NPORT-1:0]               fifo_empty;
    logic [NPORT-1:0][DATA_W-1:0]   fifo_head;
    logic [NPORT-1:0][LINK_WIDTH-1:0] link_in;
    logic [NPORT-1:0][LINK_WIDTH-1:0] link_out;

    assign link_in[0] = in_from_east;
    assign link_in[1] = in_from_west;
    assign link_in[2] = in_from_south;

    for (genvar p = 0; p < NPORT; p++) begin : g_unpack
        assign src_valid[p] = link_in[p][VLD];
        assign dst_ready[p] = link_in[p][RDY];
        assign src_data[p]  = link_in[p][DATA_W-1:0];
    end

    // Unrouted sides leave some link fields unread by design.
    logic unused_links;
    assign unused_links = ^{src_valid, dst_ready, src_data};

    // ------------------------------------------------------------------
    // Run latch: once set, only reset clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            run <= 1'b0;
        end else if (ap_start) begin
            run <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-destination FIFO with its source mux
    // ------------------------------------------------------------------
    for (genvar d = 0; d < NPORT; d++) begin : g_dst
        localparam int SRC = src_of(d);
        if (SRC != int'(pe_link_pkg::SRC_NONE)) begin : g_fifo
            localparam int S = SRC - 1;
            logic push;
            logic pop;

            assign push = run & src_valid[S] & ~fifo_full[d];
            assign pop  = run & ~fifo_empty[d] & dst_ready[d];

            pe_link_fifo #(
                .DATA_WIDTH (DATA_W),
                .DEPTH      (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push),
                .din   (src_data[S]),
                .pop   (pop),
                .dout  (fifo_head[d]),
                .full  (fifo_full[d]),
                .empty (fifo_empty[d])
            );
        end else begin : g_none
            assign fifo_full[d]  = 1'b0;
            assign fifo_empty[d] = 1'b1;
            assign fifo_head[d]  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Ready demux: each source sees the fullness of the FIFO it feeds.
    // Driven from registered state only, so no combinational path from
    // any input valid to any output ready.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < NPORT; s++) begin : g_src
        localparam int D = dst_of(s);
        if (D >= 0) begin : g_fed
            assign src_ready[s] = run & ~fifo_full[D];
        end else begin : g_idle
            assign src_ready[s] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NPORT; p++) begin : g_pack
        assign link_out[p] = {run & ~fifo_empty[p], src_ready[p], fifo_head[p]};
    end

    assign out_to_east  = link_out[0];
    assign out_to_west  = link_out[1];
    assign out_to_south = link_out[2];

endmodule

// File: tb/tb_pe_route3.sv
// -----------------------------------------------------------------------------
// tb_pe_route3
// Directed bench for pe_route3. Two instances share clock/reset/ap_start:
//   u_basic : SRC_EAST=2 (west -> east), other destinations unrouted
//   u_multi : SRC_EAST=3, SRC_WEST=2 (loopback), SRC_SOUTH=1
// Inputs are driven on the falling edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_pe_route3;

    localparam int W  = 130;
    localparam int DW = 128;
    localparam int VB = W - 1;
    localparam int RB = W - 2;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         ap_start = 1'b0;

    logic [W-1:0] a_ie = '0, a_iw = '0, a_is = '0;
    logic [W-1:0] a_oe, a_ow, a_os;
    logic [W-1:0] m_ie = '0, m_iw = '0, m_is = '0;
    logic [W-1:0] m_oe, m_ow, m_os;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  outs [6];
    logic [DW-1:0] q_e[$];
    logic [DW-1:0] q_w[$];
    logic [DW-1:0] q_s[$];

    always #5 clk = ~clk;

    pe_route3 #(
        .LINK_WIDTH (W), .FIFO_DEPTH (4),
        .SRC_EAST (2), .SRC_WEST (0), .SRC_SOUTH (0)
    ) u_basic (
        .clk (clk), .reset (reset), .ap_start (ap_start),
        .in_from_east (a_ie), .in_from_west (a_iw), .in_from_south (a_is),
        .out_to_east (a_oe), .out_to_west (a_ow), .out_to_south (a_os)
    );

    pe_route3 #(
        .LINK_WIDTH (W), .FIFO_DEPTH (4),
        .SRC_EAST (3), .SRC_WEST (2), .SRC_SOUTH (1)
    ) u_multi (
        .clk (clk), .reset (reset), .ap_start (ap_start),
        .in_from_east (m_ie), .in_from_west (m_iw), .in_from_south (m_is),
        .out_to_east (m_oe), .out_to_west (m_ow), .out_to_south (m_os)
    );

    function automatic logic [W-1:0] lnk(input logic v, input logic r,
                                         input logic [DW-1:0] d);
        return {v, r, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ap_start = 1'b0;
        a_ie = lnk(1'b1, 1'b1, DW'('hFF)); a_iw = a_ie; a_is = a_ie;
        m_ie = a_ie; m_iw = a_ie; m_is = a_ie;
        tick();
        tick();
        outs = '{a_oe, a_ow, a_os, m_oe, m_ow, m_os};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outs[i] !== '0) begin
                errors++;
                $display("FAIL reset_out%0d: got %h expected 0", i, outs[i]);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            outs = '{a_oe, a_ow, a_os, m_oe, m_ow, m_os};
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (outs[i] !== '0) begin
                    errors++;
                    $display("FAIL idle_out%0d: got %h expected 0", i, outs[i]);
                end
            end
        end
        a_ie = '0; a_iw = '0; a_is = '0;
        m_ie = '0; m_iw = '0; m_is = '0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        // Run set, nothing was written while idle: only the ready bits rise.
        outs = '{a_oe, a_ow, a_os, m_oe, m_ow, m_os};
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] exp_o;
            exp_o = (i == 1 || i >= 3) ? lnk(1'b0, 1'b1, '0) : '0;
            checks++;
            if (outs[i] !== exp_o) begin
                errors++;
                $display("FAIL run_out%0d: got %h expected %h", i, outs[i], exp_o);
            end
        end
    endtask

    task automatic test_basic_route();
        a_ie = lnk(1'b0, 1'b1, '0);
        a_iw = lnk(1'b1, 1'b0, DW'('hA5));
        tick();
        checks++;
        if (a_oe !== lnk(1'b1, 1'b0, DW'('hA5))) begin
            errors++;
            $display("FAIL basic_first: got %h expected valid A5", a_oe);
        end
        checks++;
        if (a_ow !== lnk(1'b0, 1'b1, '0)) begin
            errors++;
            $display("FAIL basic_ready1: got %h expected ready only", a_ow);
        end
        a_iw = lnk(1'b1, 1'b0, DW'('h5A));
        tick();
        checks++;
        if (a_oe !== lnk(1'b1, 1'b0, DW'('h5A))) begin
            errors++;
            $display("FAIL basic_second: got %h expected valid 5A", a_oe);
        end
        checks++;
        if (a_ow[RB] !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready2: got %b expected 1", a_ow[RB]);
        end
        a_iw = '0;
        tick();
        checks++;
        if (a_oe !== '0) begin
            errors++;
            $display("FAIL basic_drained: got %h expected 0", a_oe);
        end
    endtask

    task automatic test_backpressure();
        a_ie = lnk(1'b0, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            logic exp_r;
            exp_r = (k < 4);
            checks++;
            if (a_ow[RB] !== exp_r) begin
                errors++;
                $display("FAIL bp_ready%0d: got %b expected %b", k, a_ow[RB], exp_r);
            end
            a_iw = lnk(1'b1, 1'b0, DW'(32'h10 + k));
            tick();
        end
        a_iw = '0;
        a_ie = lnk(1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_oe !== lnk(1'b1, 1'b0, DW'(32'h10 + i))) begin
                errors++;
                $display("FAIL bp_word%0d: got %h expected valid %0h", i, a_oe, 32'h10 + i);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (a_ow[RB] !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_ready_back: got %b expected 1", a_ow[RB]);
                end
            end
        end
        checks++;
        if (a_oe !== '0) begin
            errors++;
            $display("FAIL bp_empty: got %h expected 0", a_oe);
        end
    endtask

    task automatic test_back_to_back();
        int snd;
        int rcv;
        a_ie = lnk(1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            a_iw = lnk(1'b1, 1'b0, DW'(32'h20 + k));
            tick();
        end
        checks++;
        if (a_ow[RB] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: got ready %b expected 0", a_ow[RB]);
        end
        snd = 4;
        rcv = 0;
        a_ie = lnk(1'b0, 1'b1, '0);
        for (int c = 0; c < 40 && rcv < 10; c++) begin
            a_iw = lnk(1'b1, 1'b0, DW'(32'h20 + snd));
            if (a_ow[RB] === 1'b1) snd++;
            if (a_oe[VB] === 1'b1) begin
                checks++;
                if (a_oe[DW-1:0] !== DW'(32'h20 + rcv)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h expected %0h", rcv, a_oe[DW-1:0], 32'h20 + rcv);
                end
                rcv++;
            end
            tick();
        end
        checks++;
        if (rcv < 10) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d words expected 10", rcv);
        end
        a_iw = '0;
        for (int c = 0; c < 12; c++) begin
            if (a_oe[VB] === 1'b1) begin
                checks++;
                if (a_oe[DW-1:0] !== DW'(32'h20 + rcv)) begin
                    errors++;
                    $display("FAIL b2b_drain%0d: got %h expected %0h", rcv, a_oe[DW-1:0], 32'h20 + rcv);
                end
                rcv++;
            end
            tick();
        end
        checks++;
        if (rcv !== snd) begin
            errors++;
            $display("FAIL b2b_count: got %0d words expected %0d", rcv, snd);
        end
    endtask

    task automatic test_three_streams();
        logic          ve, vw, vs, re, rw, rs;
        logic [DW-1:0] de, dw, ds, exp_d;
        q_e.delete(); q_w.delete(); q_s.delete();
        a_ie = '0; a_iw = '0; a_is = '0;
        for (int c = 0; c < 240; c++) begin
            if (c < 200) begin
                ve = 1'($urandom_range(0, 1)); vw = 1'($urandom_range(0, 1));
                vs = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
                rw = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            end else begin
                ve = 1'b0; vw = 1'b0; vs = 1'b0;
                re = 1'b1; rw = 1'b1; rs = 1'b1;
            end
            de = DW'($urandom); dw = DW'($urandom); ds = DW'($urandom);
            m_ie = lnk(ve, re, de);
            m_iw = lnk(vw, rw, dw);
            m_is = lnk(vs, rs, ds);
            // east -> south, west -> west, south -> east
            if (ve && m_oe[RB] === 1'b1) q_s.push_back(de);
            if (vw && m_ow[RB] === 1'b1) q_w.push_back(dw);
            if (vs && m_os[RB] === 1'b1) q_e.push_back(ds);
            if (m_oe[VB] === 1'b1 && re) begin
                checks++;
                exp_d = (q_e.size() > 0) ? q_e.pop_front() : '1;
                if (m_oe[DW-1:0] !== exp_d) begin
                    errors++;
                    $display("FAIL tri_east c%0d: got %h expected %h", c, m_oe[DW-1:0], exp_d);
                end
            end
            if (m_ow[VB] === 1'b1 && rw) begin
                checks++;
                exp_d = (q_w.size() > 0) ? q_w.pop_front() : '1;
                if (m_ow[DW-1:0] !== exp_d) begin
                    errors++;
                    $display("FAIL tri_west c%0d: got %h expected %h", c, m_ow[DW-1:0], exp_d);
                end
            end
            if (m_os[VB] === 1'b1 && rs) begin
                checks++;
                exp_d = (q_s.size() > 0) ? q_s.pop_front() : '1;
                if (m_os[DW-1:0] !== exp_d) begin
                    errors++;
                    $display("FAIL tri_south c%0d: got %h expected %h", c, m_os[DW-1:0], exp_d);
                end
            end
            tick();
        end
        checks++;
        if ((q_e.size() + q_w.size() + q_s.size()) != 0) begin
            errors++;
            $display("FAIL tri_leftover: got %0d/%0d/%0d words expected 0", q_e.size(), q_w.size(), q_s.size());
        end
        checks++;
        if ({m_oe[VB], m_ow[VB], m_os[VB]} !== 3'b000) begin
            errors++;
            $display("FAIL tri_valid_end: got %b expected 000", {m_oe[VB], m_ow[VB], m_os[VB]});
        end
        m_ie = '0; m_iw = '0; m_is = '0;
    endtask

    task automatic test_reset_mid();
        a_ie = lnk(1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            a_iw = lnk(1'b1, 1'b0, DW'(32'h30 + k));
            tick();
        end
        a_iw = '0;
        checks++;
        if (a_oe !== lnk(1'b1, 1'b0, DW'('h30))) begin
            errors++;
            $display("FAIL mid_queued: got %h expected valid 30", a_oe);
        end
        reset = 1'b1;
        tick();
        outs = '{a_oe, a_ow, a_os, m_oe, m_ow, m_os};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outs[i] !== '0) begin
                errors++;
                $display("FAIL mid_reset_out%0d: got %h expected 0", i, outs[i]);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({a_oe, a_ow} !== '0) begin
            errors++;
            $display("FAIL mid_norun: got %h %h expected 0", a_oe, a_ow);
        end
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        checks++;
        if (a_oe !== '0 || a_ow[RB] !== 1'b1) begin
            errors++;
            $display("FAIL mid_rerun: got east %h west ready %b expected 0 and 1", a_oe, a_ow[RB]);
        end
        a_ie = lnk(1'b0, 1'b1, '0);
        a_iw = lnk(1'b1, 1'b0, DW'('h40));
        tick();
        a_iw = '0;
        checks++;
        if (a_oe !== lnk(1'b1, 1'b0, DW'('h40))) begin
            errors++;
            $display("FAIL mid_fresh: got %h expected valid 40", a_oe);
        end
        tick();
        checks++;
        if (a_oe !== '0) begin
            errors++;
            $display("FAIL mid_no_stale: got %h expected 0", a_oe);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_route();
        test_backpressure();
        test_back_to_back();
        test_three_streams();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
